cam_capture_ctrl: RTL

Frame-capture controller between the camera pixel interface (pclk/vsync/href/8-bit data) and the frame buffer write port. On a software/top-level start request it arms on the next frame boundary and captures exactly one frame. It packs byte pairs into 16-bit RGB565 pixels, generates linear frame-buffer write addresses, and reports completion and error status. It is the block that sequences the camera datapath for the face-detection pipeline; it also runs unchanged against the camera simulator in simulation.

---
 rtl/cam_pkg.sv | 29 ++
 rtl/cam_byte_packer.sv | 53 +++++
 rtl/cam_capture_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera frame-capture path.
// Imported by the capture controller and its byte packer.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SYNC,
    CAPTURE,
    DONE
  } cam_state_t;

  localparam int DEFAULT_H_PIXELS = 160;
  localparam int DEFAULT_V_LINES  = 120;
  localparam int DEFAULT_ADDR_W   = 15;
  localparam int BYTES_PER_PIXEL  = 2;

  // Phase value at which the byte in flight completes a pixel.
  localparam logic LAST_PHASE = 1'(BYTES_PER_PIXEL - 1);

  function automatic logic rising(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic falling(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Packs consecutive camera bytes into 16-bit pixels {first, second}.
// The write strobe is registered and lines up with the registered pixel word.
module cam_byte_packer
  import cam_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        href,
  input  logic [7:0]  data,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        phase,
  output logic        pix_stb
);

  logic        phase_reg;
  logic [7:0]  hi_byte_reg;
  logic [15:0] wr_data_reg;
  logic        wr_en_reg;
  logic        byte_stb;

  assign byte_stb = en & href;
  assign pix_stb  = byte_stb & (phase_reg == LAST_PHASE);

  always_ff @(posedge pclk) begin
    if (rst) begin
      phase_reg   <= 1'b0;
      hi_byte_reg <= 8'h00;
      wr_data_reg <= 16'h0000;
      wr_en_reg   <= 1'b0;
    end else begin
      wr_en_reg <= pix_stb;
      if (clr) begin
        phase_reg <= 1'b0;
      end else if (byte_stb) begin
        phase_reg <= ~phase_reg;
      end
      if (byte_stb && (phase_reg != LAST_PHASE)) begin
        hi_byte_reg <= data;
      end
      if (pix_stb) begin
        wr_data_reg <= {hi_byte_reg, data};
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_data = wr_data_reg;
  assign phase   = phase_reg;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Single-frame capture controller: arms on start, waits for a full vsync pulse,
// then writes one frame of packed pixels to linear frame-buffer addresses.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_PIXELS = DEFAULT_H_PIXELS,
  parameter int V_LINES  = DEFAULT_V_LINES,
  parameter int ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int PX_W = $clog2(H_PIXELS + 1);
  localparam int LN_W = $clog2(V_LINES + 1);

  cam_state_t        state_reg, state_next;
  logic              vsync_q_reg, href_q_reg;
  logic [PX_W-1:0]   px_cnt_reg;
  logic [LN_W-1:0]   line_cnt_reg;
  logic [ADDR_W-1:0] line_base_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic              err_reg;

  logic vsync_rise, vsync_fall, href_fall;
  logic capturing, line_full, last_line;
  logic end_full, end_short;
  logic pk_en, pk_clr, pk_phase, pix_stb;

  assign vsync_rise = rising(vsync, vsync_q_reg);
  assign vsync_fall = falling(vsync, vsync_q_reg);
  assign href_fall  = falling(href, href_q_reg);

  assign capturing = (state_reg == CAPTURE);
  assign line_full = (px_cnt_reg == PX_W'(H_PIXELS));
  assign last_line = (line_cnt_reg == LN_W'(V_LINES - 1));
  assign end_full  = capturing & href_fall & last_line;
  assign end_short = capturing & vsync_rise & ~end_full;

  // Bytes beyond a full line never reach the packer; outside CAPTURE the phase is held at 0.
  assign pk_en  = capturing & ~line_full;
  assign pk_clr = ~capturing | href_fall;

  cam_byte_packer u_packer (
    .pclk    (pclk),
    .rst     (rst),
    .en      (pk_en),
    .clr     (pk_clr),
    .href    (href),
    .data    (data),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .phase   (pk_phase),
    .pix_stb (pix_stb)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)                  state_next = ARM;
      ARM:     if (vsync_rise)             state_next = SYNC;
      SYNC:    if (vsync_fall)             state_next = CAPTURE;
      CAPTURE: if (end_full || vsync_rise) state_next = DONE;
      DONE:                                state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_reg)
      IDLE:    busy = 1'b0;
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q_reg   <= 1'b0;
      href_q_reg    <= 1'b0;
      px_cnt_reg    <= '0;
      line_cnt_reg  <= '0;
      line_base_reg <= '0;
      wr_addr_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      vsync_q_reg <= vsync;
      href_q_reg  <= href;
      if ((state_reg == IDLE) && start) begin
        err_reg       <= 1'b0;
        px_cnt_reg    <= '0;
        line_cnt_reg  <= '0;
        line_base_reg <= '0;
      end else if (capturing) begin
        if (pix_stb) begin
          wr_addr_reg <= line_base_reg + ADDR_W'(px_cnt_reg);
          px_cnt_reg  <= px_cnt_reg + PX_W'(1);
        end
        // Line base accumulates by H_PIXELS per line instead of multiplying.
        if (href_fall) begin
          px_cnt_reg    <= '0;
          line_cnt_reg  <= line_cnt_reg + LN_W'(1);
          line_base_reg <= line_base_reg + ADDR_W'(H_PIXELS);
          if (pk_phase) begin
            err_reg <= 1'b1;
          end
        end
        if ((href && line_full) || end_short) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign wr_addr = wr_addr_reg;
  assign err     = err_reg;

endmodule
